pipe_mult: RTL and testbench
============================

# pipe_mult

Parametrised, pipelined integer multiplier for the execute stage. Splits the multiplier operand into `STAGES` equal chunks, one per pipeline stage, then applies a final sign and select stage. Supports low-half, signed-high, unsigned-high and signed-by-unsigned-high results. Adds a tag passthrough, global stall and flush, so the scheduler can issue one multiply per cycle and squash in-flight operations on mispredict.

## Interface
Parameters:
- `WIDTH`, 64: operand and result width. `WIDTH % STAGES == 0` is required.
- `STAGES`, 8: partial-product stages. `CHUNK = WIDTH/STAGES` multiplier bits are consumed per stage.
- `TAG_W`, 6: width of the opaque tag carried alongside each operation.

Ports:
- `clock`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: issue valid. Accepted only when `stall`=0 and `flush`=0.
- `op`  in  2: operation code, `mult_pkg::mul_op_t`.
- `a`  in  WIDTH: multiplicand (rs1).
- `b`  in  WIDTH: multiplier (rs2).
- `tag_in`  in  TAG_W: tag returned with the result.
- `stall`  in  1: freezes every pipeline register, including the output registers.
- `flush`  in  1: invalidates all in-flight operations.
- `done`  out  1: result valid. High for exactly one cycle per operation, unless stalled.
- `result`  out  WIDTH: selected half of the product.
- `tag_out`  out  TAG_W: tag of the completing operation.

## Operation
Op encodings (RISC-V order): MULL=00, MULH=01, MULHSU=10, MULHU=11.

Input capture:
- Compute the operand signs:
  - `sa` = `a[W-1]` when op is MULH or MULHSU.
  - `sb` = `b[W-1]` when op is MULH.
- Form unsigned magnitudes `|a|` and `|b|`, each WIDTH bits. `2^(W-1)` is representable, so no overflow occurs.
- Set `neg = sa ^ sb`.
- Zero-extend `|a|` to the 2·WIDTH-bit multiplicand.

Stage k (k = 0 … STAGES-1):
- `prod += mplier[CHUNK-1:0] * mcand`, on a 2·WIDTH-bit accumulator.
- `mplier >>= CHUNK`; `mcand <<= CHUNK`, truncated to 2·WIDTH bits.
- Carry `valid`, `op`, `neg` and `tag` alongside the data.

Final stage:
- `p = neg ? -prod : prod`, in 2·WIDTH bits, two's complement.
- `result = (op==MULL) ? p[W-1:0] : p[2W-1:W]`.

Ordering: operations complete strictly in issue order.

## Timing
- Latency is `STAGES+1` cycles. `start` sampled at edge t gives `done`=1 in the cycle after edge t+STAGES+1 (9 cycles for the defaults).
- Throughput is one operation per cycle with no bubbles.
- `stall`=1:
  - No register changes.
  - `start` is ignored.
  - `done`, `result` and `tag_out` hold their values. A `done` held during a stall represents one completion, not several.
- `flush`=1:
  - All valid bits, including `done`, clear at the next edge.
  - A same-cycle `start` is dropped.
  - `flush` overrides `stall`.
  - Data registers are don't-care.
- `reset`:
  - Clears every valid bit.
  - Sets `done`=0, `result`=0 and `tag_out`=0 at the next edge.
  - Overrides `flush` and `stall`.
  - Any operation in flight is lost.
- Data registers in the stages need no reset; only the valid bits and the output registers are reset.

## Structure
- Package `mult_pkg`: `mul_op_t` enum (MUL_MULL, MUL_MULH, MUL_MULHSU, MUL_MULHU).
- Sub-module `mult_pipe_stage`, one per chunk, instantiated with a generate loop.
  - Parameters: WIDTH, CHUNK, TAG_W.
  - Registers: accumulator, mplier, mcand, valid, op, neg and tag.
  - Takes stall and flush as inputs.
- The top level contains the input sign/magnitude logic, the stage chain, and the final negate/select output register.

## Test plan
All scenarios use WIDTH=64, STAGES=8.
1. MULL, a=3, b=5, tag=7 → 9 cycles later `done`=1 for one cycle, `result`=15, `tag_out`=7.
2. a=b=0xFFFF_FFFF_FFFF_FFFF:
   - MULH → result 0.
   - MULHU → result 0xFFFF_FFFF_FFFF_FFFE.
   - MULL → result 1.
3. Signed and mixed-sign high results:
   - MULHSU, a=0xFFFF_FFFF_FFFF_FFFF, b=2 → result 0xFFFF_FFFF_FFFF_FFFF.
   - MULH, a=b=0x8000_0000_0000_0000 → result 0x4000_0000_0000_0000.
4. Back-to-back issue of 9 operations with tags 0–8 and mixed ops → `done` high for 9 consecutive cycles, tags returned in order, each result matching a reference model.
5. Stall, then flush:
   - Issue an operation, then stall for 3 cycles at cycle 4 → `done` appears 3 cycles late with the correct value. `done` held under stall counts as a single completion.
   - Issue 4 operations, then flush at cycle 5 → no `done`. An operation issued after the flush completes normally.
6. Reset asserted at cycle 3 of an operation → the next cycle has `done`=0, `result`=0 and `tag_out`=0, and no late `done` ever appears.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: operation encodings shared by the pipelined multiplier.
// Ports: none (package). Encodings follow RISC-V M-extension order.
package mult_pkg;
    typedef enum logic [1:0] {
        MUL_MULL   = 2'b00,
        MUL_MULH   = 2'b01,
        MUL_MULHSU = 2'b10,
        MUL_MULHU  = 2'b11
    } mul_op_t;
endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one shift-and-add step consuming CHUNK multiplier bits.
// Ports: clock/reset/stall/flush control; *_i from the previous stage,
//        *_o registered towards the next stage (valid, op, neg, tag,
//        accumulator prod, remaining multiplier mplier, shifted multiplicand mcand).
module mult_pipe_stage #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int TAG_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_i,
    input  logic [1:0]         op_i,
    input  logic               neg_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   mplier_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    output logic               valid_o,
    output logic [1:0]         op_o,
    output logic               neg_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   mplier_o,
    output logic [2*WIDTH-1:0] mcand_o
);
    logic               valid_q, valid_d, neg_q, neg_d;
    logic [1:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    always_comb begin
        valid_d  = flush ? 1'b0 : (stall ? valid_q : valid_i);
        op_d     = stall ? op_q : op_i;
        neg_d    = stall ? neg_q : neg_i;
        tag_d    = stall ? tag_q : tag_i;
        prod_d   = stall ? prod_q : prod_i + {{(2*WIDTH-CHUNK){1'b0}}, mplier_i[CHUNK-1:0]} * mcand_i;
        mplier_d = stall ? mplier_q : mplier_i >> CHUNK;
        mcand_d  = stall ? mcand_q : mcand_i << CHUNK;
    end

    // Only the valid bit is reset; data is qualified by it.
    always_ff @(posedge clock) begin
        valid_q  <= reset ? 1'b0 : valid_d;
        op_q     <= op_d;
        neg_q    <= neg_d;
        tag_q    <= tag_d;
        prod_q   <= prod_d;
        mplier_q <= mplier_d;
        mcand_q  <= mcand_d;
    end

    assign valid_o  = valid_q;
    assign op_o     = op_q;
    assign neg_o    = neg_q;
    assign tag_o    = tag_q;
    assign prod_o   = prod_q;
    assign mplier_o = mplier_q;
    assign mcand_o  = mcand_q;
endmodule

// File: rtl/pipe_mult.sv
// pipe_mult: pipelined WIDTHxWIDTH multiplier (MULL/MULH/MULHSU/MULHU), latency STAGES+1.
// Ports: clock, reset (sync, active-high); start/op/a/b/tag_in issue;
//        stall freezes all registers, flush kills in-flight ops;
//        done/result/tag_out report one completion per operation.
module pipe_mult
    import mult_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 8,
    parameter int TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             stall,
    input  logic             flush,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out
);
    localparam int CHUNK = WIDTH / STAGES;

    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               cap_valid_q, cap_valid_d, cap_neg_q, cap_neg_d;
    logic [1:0]         cap_op_q, cap_op_d;
    logic [TAG_W-1:0]   cap_tag_q, cap_tag_d;
    logic [WIDTH-1:0]   cap_a_q, cap_a_d, cap_b_q, cap_b_d;

    // Signed operands are folded to magnitudes; -2^(W-1) maps to itself, which is its magnitude.
    always_comb begin
        sa          = (op == MUL_MULH || op == MUL_MULHSU) & a[WIDTH-1];
        sb          = (op == MUL_MULH) & b[WIDTH-1];
        abs_a       = sa ? -a : a;
        abs_b       = sb ? -b : b;
        cap_valid_d = flush ? 1'b0 : (stall ? cap_valid_q : start);
        cap_op_d    = stall ? cap_op_q : op;
        cap_neg_d   = stall ? cap_neg_q : sa ^ sb;
        cap_tag_d   = stall ? cap_tag_q : tag_in;
        cap_a_d     = stall ? cap_a_q : abs_a;
        cap_b_d     = stall ? cap_b_q : abs_b;
    end

    always_ff @(posedge clock) begin
        cap_valid_q <= reset ? 1'b0 : cap_valid_d;
        cap_op_q    <= cap_op_d;
        cap_neg_q   <= cap_neg_d;
        cap_tag_q   <= cap_tag_d;
        cap_a_q     <= cap_a_d;
        cap_b_q     <= cap_b_d;
    end

    logic               valid_w  [STAGES+1];
    logic [1:0]         op_w     [STAGES+1];
    logic               neg_w    [STAGES+1];
    logic [TAG_W-1:0]   tag_w    [STAGES+1];
    logic [2*WIDTH-1:0] prod_w   [STAGES+1];
    logic [WIDTH-1:0]   mplier_w [STAGES+1];
    logic [2*WIDTH-1:0] mcand_w  [STAGES+1];

    assign valid_w[0]  = cap_valid_q;
    assign op_w[0]     = cap_op_q;
    assign neg_w[0]    = cap_neg_q;
    assign tag_w[0]    = cap_tag_q;
    assign prod_w[0]   = '0;
    assign mplier_w[0] = cap_b_q;
    assign mcand_w[0]  = {{WIDTH{1'b0}}, cap_a_q};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mult_pipe_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) u_stage (
            .clock   (clock),
            .reset   (reset),
            .stall   (stall),
            .flush   (flush),
            .valid_i (valid_w[i]),
            .op_i    (op_w[i]),
            .neg_i   (neg_w[i]),
            .tag_i   (tag_w[i]),
            .prod_i  (prod_w[i]),
            .mplier_i(mplier_w[i]),
            .mcand_i (mcand_w[i]),
            .valid_o (valid_w[i+1]),
            .op_o    (op_w[i+1]),
            .neg_o   (neg_w[i+1]),
            .tag_o   (tag_w[i+1]),
            .prod_o  (prod_w[i+1]),
            .mplier_o(mplier_w[i+1]),
            .mcand_o (mcand_w[i+1])
        );
    end

    logic [2*WIDTH-1:0] p;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    always_comb begin
        p        = neg_w[STAGES] ? -prod_w[STAGES] : prod_w[STAGES];
        done_d   = flush ? 1'b0 : (stall ? done_q : valid_w[STAGES]);
        result_d = stall ? result_q : (op_w[STAGES] == MUL_MULL ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH]);
        tag_d    = stall ? tag_q : tag_w[STAGES];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_q;
endmodule

// File: tb/tb_pipe_mult.sv
// tb_pipe_mult: directed and randomized checks of pipe_mult against a queue-based reference.
module tb_pipe_mult;
    localparam int LAT = 9;

    logic        clock = 1'b0;
    logic        reset = 1'b1, start = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] a = '0, b = '0;
    logic [5:0]  tag_in = '0;
    logic        done;
    logic [63:0] result;
    logic [5:0]  tag_out;

    int vecs = 0, errs = 0;

    pipe_mult #(.WIDTH(64), .STAGES(8), .TAG_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .tag_in(tag_in), .stall(stall), .flush(flush),
        .done(done), .result(result), .tag_out(tag_out)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_fn(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] xe, ye, pr;
        xe = (o == 2'b01 || o == 2'b10) ? {{64{x[63]}}, x} : {64'b0, x};
        ye = (o == 2'b01) ? {{64{y[63]}}, y} : {64'b0, y};
        pr = xe * ye;
        return (o == 2'b00) ? pr[63:0] : pr[127:64];
    endfunction

    typedef struct {
        int          rem;
        logic [63:0] res;
        logic [5:0]  tag;
    } op_t;

    op_t         q[$];
    logic        e_done = 1'b0, e_known = 1'b0, started = 1'b0;
    logic [63:0] e_res = '0;
    logic [5:0]  e_tag = '0;

    // Reference: an op is returned after LAT unstalled edges; stall freezes everything.
    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            e_done = 1'b0; e_res = '0; e_tag = '0; e_known = 1'b1; started = 1'b1;
        end else if (flush) begin
            q.delete();
            e_done = 1'b0; e_known = 1'b0;
        end else if (!stall) begin
            e_done = 1'b0; e_known = 1'b0;
            if (q.size() > 0 && q[0].rem == 0) begin
                e_done = 1'b1; e_known = 1'b1; e_res = q[0].res; e_tag = q[0].tag;
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].rem--;
            if (start) q.push_back('{rem: LAT - 1, res: ref_fn(op, a, b), tag: tag_in});
        end
    end

    always @(negedge clock) begin
        if (started) begin
            vecs++;
            if (done !== e_done) begin
                errs++;
                $display("FAIL done @%0t: got %b expected %b", $time, done, e_done);
            end
            if ((e_done || e_known) && result !== e_res) begin
                errs++;
                $display("FAIL result @%0t: got %h expected %h", $time, result, e_res);
            end
            if ((e_done || e_known) && tag_out !== e_tag) begin
                errs++;
                $display("FAIL tag @%0t: got %0d expected %0d", $time, tag_out, e_tag);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [5:0] t, input logic st, input logic fl, input logic rs);
        start = s; op = o; a = x; b = y; tag_in = t; stall = st; flush = fl; reset = rs;
        @(posedge clock);
        #1;
        start = 1'b0; stall = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'b00, 64'd0, 64'd0, 6'd0, 0, 0, 0);
    endtask

    // Issue, optionally stall, then wait for done and check latency, result and tag.
    task automatic run_one(input string nm, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                           input logic [5:0] t, input logic [63:0] exp, input int stall_cyc, input int exp_lat);
        int n;
        chk({nm, "_model"}, ref_fn(o, x, y), exp);
        cyc(1, o, x, y, t, 0, 0, 0);
        n = 0;
        if (stall_cyc > 0) begin
            idle(3); n += 3;
            for (int i = 0; i < stall_cyc; i++) cyc(0, 2'b00, 64'd0, 64'd0, 6'd0, 1, 0, 0);
            n += stall_cyc;
        end
        while (!done && n < 40) begin idle(1); n++; end
        chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
        chk({nm, "_res"}, result, exp);
        chk({nm, "_tag"}, 64'(tag_out), 64'(t));
        if (stall_cyc > 0) begin
            cyc(0, 2'b00, 64'd0, 64'd0, 6'd0, 1, 0, 0);
            chk({nm, "_held"}, 64'(done), 64'd1);
        end
        idle(1);
        chk({nm, "_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [5:0] tags[$];
        logic [63:0] sp[4];
        sp[0] = 64'd0; sp[1] = '1; sp[2] = 64'h8000_0000_0000_0000; sp[3] = 64'h7FFF_FFFF_FFFF_FFFF;

        idle(0);
        cyc(0, 2'b00, 64'd0, 64'd0, 6'd0, 0, 0, 1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_res", result, 64'd0);
        chk("reset_tag", 64'(tag_out), 64'd0);
        idle(2);

        run_one("mull_3x5", 2'b00, 64'd3, 64'd5, 6'd7, 64'd15, 0, LAT);
        run_one("mulh_m1", 2'b01, '1, '1, 6'd1, 64'd0, 0, LAT);
        run_one("mulhu_m1", 2'b11, '1, '1, 6'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, LAT);
        run_one("mull_m1", 2'b00, '1, '1, 6'd3, 64'd1, 0, LAT);
        run_one("mulhsu", 2'b10, '1, 64'd2, 6'd4, '1, 0, LAT);
        run_one("mulh_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd5,
                64'h4000_0000_0000_0000, 0, LAT);

        // Back-to-back issue, tags 0..8.
        for (int i = 0; i < 9; i++)
            cyc(1, 2'(i), 64'($urandom) << 32 | 64'($urandom), 64'($urandom) << 32 | 64'($urandom), 6'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (done) tags.push_back(tag_out);
        end
        chk("b2b_count", 64'(tags.size()), 64'd9);
        foreach (tags[i]) chk("b2b_order", 64'(tags[i]), 64'(i));

        run_one("stall3", 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 6'd9, '1, 3, LAT + 3);

        // Flush kills every in-flight op; a later op completes normally.
        for (int i = 0; i < 4; i++) cyc(1, 2'b00, 64'(i + 1), 64'd3, 6'(20 + i), 0, 0, 0);
        idle(1);
        cyc(1, 2'b00, 64'd9, 64'd9, 6'd30, 0, 1, 0);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            chk("flush_no_done", 64'(done), 64'd0);
        end
        run_one("post_flush", 2'b11, 64'h1_0000_0000, 64'h1_0000_0000, 6'd33, 64'd1, 0, LAT);

        // Reset mid-flight.
        cyc(1, 2'b00, 64'd11, 64'd13, 6'd44, 0, 0, 0);
        idle(2);
        cyc(0, 2'b00, 64'd0, 64'd0, 6'd0, 0, 0, 1);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_res", result, 64'd0);
        chk("rst_mid_tag", 64'(tag_out), 64'd0);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            chk("rst_no_late", 64'(done), 64'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic [63:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : {32'($urandom), 32'($urandom)};
            y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : {32'($urandom), 32'($urandom)};
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), x, y, 6'($urandom_range(0, 63)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
